// File: rtl/mac_stream_pkg.sv
// Shared types and helpers for the streaming matrix-multiply engine.
//   state_t  : engine phase (operand load, compute, result drain)
//   idx_w    : counter/address width for a given depth, never below 1 bit
//   ext_mul  : sign- or zero-extend two operands of width dw and multiply;
//              callers keep the low bits they need (product wraps modulo
//              2^width, so truncation is exact)
package mac_stream_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Widest operand the multiply helper supports, and its internal width.
  localparam int MAX_DW = 64;
  localparam int PROD_W = 2 * MAX_DW + 32;

  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [PROD_W-1:0] ext_mul(
    input logic [MAX_DW-1:0] a,
    input logic [MAX_DW-1:0] b,
    input logic              is_signed,
    input int                dw
  );
    logic signed [PROD_W-1:0] ax;
    logic signed [PROD_W-1:0] bx;
    int                       sh;
    sh = PROD_W - dw;
    ax = {{(PROD_W-MAX_DW){1'b0}}, a};
    bx = {{(PROD_W-MAX_DW){1'b0}}, b};
    // Push the operand's top bit to the MSB and shift back arithmetically
    // to replicate it; zero-extended operands are already correct.
    if (is_signed) begin
      ax = (ax <<< sh) >>> sh;
      bx = (bx <<< sh) >>> sh;
    end
    return ax * bx;
  endfunction

endpackage

// File: rtl/mac_stream_pe.sv
// Single multiply-accumulate element.
//   a, b      : operands (DW bits), interpreted per is_signed
//   seed      : starting value used instead of acc when load_seed is high
//   en        : update the accumulator this cycle
//   acc       : registered running sum (RW bits, wraps modulo 2^RW)
module mac_stream_pe
  import mac_stream_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 68
) (
  input  logic          clk,
  input  logic          en,
  input  logic          load_seed,
  input  logic          is_signed,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [RW-1:0] seed,
  output logic [RW-1:0] acc
);

  logic [RW-1:0] prod_p0;
  logic [RW-1:0] base_p0;

  always_comb begin
    prod_p0 = RW'(ext_mul(MAX_DW'(a), MAX_DW'(b), is_signed, DW));
    base_p0 = load_seed ? seed : acc;
  end

  // p0 -> p1: accumulator register. Every dot product starts with a seed,
  // so the register never needs a reset value.
  always_ff @(posedge clk) begin
    if (en) acc <= base_p0 + prod_p0;
  end

endmodule

// File: rtl/mac_stream_engine.sv
// Streaming matrix-multiply engine: C = A x B, or C += A x B.
//   cfg_signed/cfg_accumulate : job options, captured on the first A element
//   in_val/in_rdy/in_data     : operand stream, M*K A then K*N B, row-major
//   out_val/out_rdy/out_data  : C stream, row-major, out_last on final element
//   busy                      : high while computing or draining
//   done                      : one-cycle pulse after the final C handshake
module mac_stream_engine
  import mac_stream_pkg::*;
#(
  parameter int M  = 8,
  parameter int K  = 6,
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int RW = 2*DW + $clog2(K) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_signed,
  input  logic          cfg_accumulate,
  input  logic          in_val,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [RW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int MK = M * K;
  localparam int KN = K * N;
  localparam int MN = M * N;
  localparam int AW = idx_w(MK);
  localparam int BW = idx_w(KN);
  localparam int CW = idx_w(MN);
  localparam int LW = idx_w((MK > KN) ? MK : KN);
  localparam int IW = idx_w(M);
  localparam int JW = idx_w(N);
  localparam int KW = idx_w(K);

  state_t        state, state_nxt;
  logic [LW-1:0] ld_idx;
  logic [IW-1:0] ci;
  logic [JW-1:0] cj;
  logic [KW-1:0] ck;
  logic [CW-1:0] oidx;
  logic          cfg_signed_q, cfg_acc_q;
  logic          wb_vld_p1;
  logic [CW-1:0] wb_addr_p1;

  logic [DW-1:0] a_mem [MK];
  logic [DW-1:0] b_mem [KN];
  logic [RW-1:0] c_mem [MN];

  logic [AW-1:0] a_addr;
  logic [BW-1:0] b_addr;
  logic [CW-1:0] c_addr;
  logic [RW-1:0] seed;
  logic [RW-1:0] pe_acc;
  logic          ld_last, mac_last, o_last, in_hs, out_hs;

  always_comb begin
    a_addr   = AW'(int'(ci) * K + int'(ck));
    b_addr   = BW'(int'(ck) * N + int'(cj));
    c_addr   = CW'(int'(ci) * N + int'(cj));
    seed     = cfg_acc_q ? c_mem[c_addr] : '0;
    ld_last  = (state == LOAD_A) ? (ld_idx == LW'(MK-1)) : (ld_idx == LW'(KN-1));
    mac_last = (ci == IW'(M-1)) && (cj == JW'(N-1)) && (ck == KW'(K-1));
    o_last   = (oidx == CW'(MN-1));
  end

  assign in_hs  = in_val & in_rdy;
  assign out_hs = out_val & out_rdy;

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD_A: begin
        in_rdy = 1'b1;
        if (in_val && ld_last) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        in_rdy = 1'b1;
        if (in_val && ld_last) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (mac_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        out_val = 1'b1;
        if (out_rdy && o_last) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  // The final dot product lands in C during the first DRAIN cycle; forward
  // it so a 1x1 result is correct on that cycle.
  always_comb begin
    out_data = '0;
    if (out_val) out_data = (wb_vld_p1 && wb_addr_p1 == oidx) ? pe_acc : c_mem[oidx];
  end

  assign out_last = out_val & o_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD_A;
      ld_idx       <= '0;
      ci           <= '0;
      cj           <= '0;
      ck           <= '0;
      oidx         <= '0;
      cfg_signed_q <= 1'b0;
      cfg_acc_q    <= 1'b0;
      wb_vld_p1    <= 1'b0;
      done         <= 1'b0;
    end else begin
      state     <= state_nxt;
      done      <= out_hs && o_last;
      wb_vld_p1 <= (state == COMPUTE) && (ck == KW'(K-1));
      if (in_hs) begin
        ld_idx <= ld_last ? '0 : ld_idx + LW'(1);
        if (state == LOAD_A && ld_idx == '0) begin
          cfg_signed_q <= cfg_signed;
          cfg_acc_q    <= cfg_accumulate;
        end
      end
      if (state == COMPUTE) begin
        if (ck == KW'(K-1)) begin
          ck <= '0;
          if (cj == JW'(N-1)) begin
            cj <= '0;
            ci <= (ci == IW'(M-1)) ? '0 : ci + IW'(1);
          end else begin
            cj <= cj + JW'(1);
          end
        end else begin
          ck <= ck + KW'(1);
        end
      end
      if (out_hs) oidx <= o_last ? '0 : oidx + CW'(1);
    end
  end

  // p0 -> p1: remember which C entry the accumulator finishes this cycle.
  always_ff @(posedge clk) begin
    wb_addr_p1 <= c_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < MK; e++) a_mem[e] <= '0;
      for (int e = 0; e < KN; e++) b_mem[e] <= '0;
      for (int e = 0; e < MN; e++) c_mem[e] <= '0;
    end else begin
      if (in_hs && state == LOAD_A) a_mem[AW'(ld_idx)] <= in_data;
      if (in_hs && state == LOAD_B) b_mem[BW'(ld_idx)] <= in_data;
      if (wb_vld_p1) c_mem[wb_addr_p1] <= pe_acc;
    end
  end

  mac_stream_pe #(
    .DW(DW),
    .RW(RW)
  ) u_pe (
    .clk      (clk),
    .en       (state == COMPUTE),
    .load_seed(ck == '0),
    .is_signed(cfg_signed_q),
    .a        (a_mem[a_addr]),
    .b        (b_mem[b_addr]),
    .seed     (seed),
    .acc      (pe_acc)
  );

endmodule

// File: tb/tb_mac_stream_engine.sv
// Self-checking bench for mac_stream_engine: directed pattern jobs plus
// randomized jobs, all compared against a plain matrix-product model.
module tb_mac_stream_engine;

  localparam int M  = 8;
  localparam int K  = 6;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 2*DW + $clog2(K) + 1;
  localparam int MK = M * K;
  localparam int KN = K * N;
  localparam int MN = M * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_signed = 1'b0;
  logic          cfg_accumulate = 1'b0;
  logic          in_val = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] in_data = '0;
  logic          out_val;
  logic          out_rdy = 1'b0;
  logic [RW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] a_m   [MK];
  logic [DW-1:0] b_m   [KN];
  logic [RW-1:0] c_mod [MN];
  logic [RW-1:0] got   [MN];
  logic [RW-1:0] neg12;

  int n_checks = 0;
  int n_errors = 0;
  bit job_sgn, job_acc, rdy_bad;

  mac_stream_engine #(.M(M), .K(K), .N(N), .DW(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_signed    (cfg_signed),
    .cfg_accumulate(cfg_accumulate),
    .in_val        (in_val),
    .in_rdy        (in_rdy),
    .in_data       (in_data),
    .out_val       (out_val),
    .out_rdy       (out_rdy),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] ext(input logic [DW-1:0] v, input bit sgn);
    return sgn ? {{(RW-DW){v[DW-1]}}, v} : {{(RW-DW){1'b0}}, v};
  endfunction

  // C = A*B (or C + A*B) with every term widened to RW bits and summed mod 2^RW.
  task automatic model_job();
    logic [RW-1:0] s;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        s = job_acc ? c_mod[i*N+j] : '0;
        for (int k = 0; k < K; k++)
          s = s + ext(a_m[i*K+k], job_sgn) * ext(b_m[k*N+j], job_sgn);
        c_mod[i*N+j] = s;
      end
  endtask

  task automatic fill_t1();
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_m[i*K+k] = DW'(4 + 2*i);
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_m[k*N+j] = DW'(2 + 2*k);
  endtask

  task automatic fill_t3();
    for (int e = 0; e < MK; e++) a_m[e] = 32'hFFFF_FFFF;
    for (int e = 0; e < KN; e++) b_m[e] = 32'd2;
  endtask

  task automatic fill_rand();
    for (int e = 0; e < MK; e++) a_m[e] = $urandom;
    for (int e = 0; e < KN; e++) b_m[e] = $urandom;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send(input logic [DW-1:0] d, input bit stress);
    if (stress) repeat ($urandom_range(0, 2)) begin
      in_val  = 1'b0;
      in_data = $urandom;
      @(posedge clk); #1;
    end
    in_val  = 1'b1;
    in_data = d;
    if (!in_rdy) rdy_bad = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
  endtask

  task automatic load_job(input bit sgn, input bit acc, input bit stress);
    job_sgn        = sgn;
    job_acc        = acc;
    rdy_bad        = 1'b0;
    cfg_signed     = sgn;
    cfg_accumulate = acc;
    for (int e = 0; e < MK; e++) begin
      send(a_m[e], stress);
      if (e == 0) begin
        cfg_signed     = 1'($urandom_range(0, 1));
        cfg_accumulate = 1'($urandom_range(0, 1));
      end
    end
    for (int e = 0; e < KN; e++) send(b_m[e], stress);
    chk("load_in_rdy", RW'(rdy_bad), RW'(0));
  endtask

  task automatic compute_drain(input bit stress, input bit junk);
    int            cyc, idx, guard, done_seen;
    bit            rdy_leak, stall_prev;
    logic [RW-1:0] held;
    model_job();
    cyc      = 0;
    rdy_leak = 1'b0;
    chk("busy_compute", RW'(busy), RW'(1));
    while (!out_val && cyc < 1000) begin
      if (junk) begin
        in_val  = 1'b1;
        in_data = $urandom;
      end
      if (in_rdy) rdy_leak = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    chk("compute_cycles", RW'(cyc), RW'(M*N*K));
    idx        = 0;
    guard      = 0;
    done_seen  = 0;
    stall_prev = 1'b0;
    held       = '0;
    while (idx < MN && guard < 4000) begin
      out_rdy = stress ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (junk) begin
        in_val  = !(out_val && out_rdy && idx == MN-1);
        in_data = $urandom;
      end
      if (in_rdy) rdy_leak = 1'b1;
      if (done) done_seen++;
      if (out_val) begin
        if (stall_prev) chk("stall_hold", out_data, held);
        if (out_rdy) begin
          got[idx] = out_data;
          chk($sformatf("c[%0d]", idx), out_data, c_mod[idx]);
          chk("out_last", RW'(out_last), RW'(idx == MN-1));
          idx++;
        end
        stall_prev = !out_rdy;
        held       = out_data;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_rdy = 1'b0;
    in_val  = 1'b0;
    chk("drain_count", RW'(idx), RW'(MN));
    chk("in_rdy_busy", RW'(rdy_leak), RW'(0));
    chk("done_early", RW'(done_seen), RW'(0));
    chk("done_pulse", RW'(done), RW'(1));
    chk("busy_after", RW'(busy), RW'(0));
    chk("in_rdy_after", RW'(in_rdy), RW'(1));
    chk("out_val_after", RW'(out_val), RW'(0));
    @(posedge clk); #1;
    chk("done_clear", RW'(done), RW'(0));
  endtask

  initial begin
    neg12 = '0 - RW'(12);
    for (int e = 0; e < MN; e++) begin
      c_mod[e] = '0;
      got[e]   = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_rdy", RW'(in_rdy), RW'(1));
    chk("rst_out_val", RW'(out_val), RW'(0));
    chk("rst_out_last", RW'(out_last), RW'(0));
    chk("rst_busy", RW'(busy), RW'(0));
    chk("rst_done", RW'(done), RW'(0));
    chk("rst_out_data", out_data, RW'(0));

    // Pattern job, overwrite
    fill_t1();
    load_job(1'b0, 1'b0, 1'b0);
    compute_drain(1'b0, 1'b0);
    chk("t1_c00", got[0], RW'(168));
    chk("t1_c73", got[MN-1], RW'(756));

    // Same operands, accumulate onto previous C
    load_job(1'b0, 1'b1, 1'b0);
    compute_drain(1'b0, 1'b0);
    chk("t2_c00", got[0], RW'(336));
    chk("t2_c73", got[MN-1], RW'(1512));

    // All-ones A: signed gives -12, unsigned gives 12*(2^32-1)
    fill_t3();
    load_job(1'b1, 1'b0, 1'b0);
    compute_drain(1'b0, 1'b0);
    chk("t3s_c00", got[0], neg12);
    chk("t3s_c73", got[MN-1], neg12);
    load_job(1'b0, 1'b0, 1'b0);
    compute_drain(1'b0, 1'b0);
    chk("t3u_c00", got[0], RW'(64'd51539607540));
    chk("t3u_c73", got[MN-1], RW'(64'd51539607540));

    // Input gaps and output backpressure
    fill_t1();
    load_job(1'b0, 1'b0, 1'b1);
    compute_drain(1'b1, 1'b0);
    chk("t4_c00", got[0], RW'(168));
    chk("t4_c73", got[MN-1], RW'(756));

    // Junk offered while busy
    load_job(1'b0, 1'b0, 1'b0);
    compute_drain(1'b0, 1'b1);
    chk("t6_c00", got[0], RW'(168));
    chk("t6_c73", got[MN-1], RW'(756));

    // Reset mid-compute, then accumulate onto the cleared C
    load_job(1'b1, 1'b1, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_in_rdy", RW'(in_rdy), RW'(1));
    chk("t5_busy", RW'(busy), RW'(0));
    chk("t5_out_val", RW'(out_val), RW'(0));
    chk("t5_out_data", out_data, RW'(0));
    for (int e = 0; e < MN; e++) c_mod[e] = '0;
    load_job(1'b0, 1'b1, 1'b0);
    compute_drain(1'b0, 1'b0);
    chk("t5_c00", got[0], RW'(168));
    chk("t5_c73", got[MN-1], RW'(756));

    // Random operands and options
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      load_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      compute_drain(1'b1, r[0]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
